treasure_report_ctrl: RTL and testbench

//  Downstream of the image processor. Samples its per-frame RESULT/SHAPE at each frame boundary.

---
 rtl/treasure_report_ctrl_if.sv | 10 +
 rtl/treasure_report_ctrl.sv | 154 +++++++++++++++
 tb/tb_treasure_report_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/treasure_report_ctrl_if.sv
// Arduino report port: 4-bit code with a VALID/ACK four-phase handshake.
// The controller drives data and valid. The Arduino side returns ack.
interface treasure_report_ctrl_if;
  logic [3:0] ARD_DATA;
  logic       ARD_VALID;
  logic       ARD_ACK;

  modport master (output ARD_DATA, output ARD_VALID, input ARD_ACK);
  modport slave  (input ARD_DATA, input ARD_VALID, output ARD_ACK);
endinterface

// File: rtl/treasure_report_ctrl.sv
// Treasure report controller.
// Samples the image processor's per-frame colour/shape code at each frame boundary.
// A code is accepted once it has been identical for STABLE_FRAMES consecutive frames.
// Each newly accepted non-empty code is reported to the Arduino over a four-phase
// VALID/ACK handshake. Unacknowledged reports are abandoned after TIMEOUT_CYCLES.
module treasure_report_ctrl #(
  parameter int STABLE_FRAMES  = 4,
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int TMO_W          = 25
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          VGA_VSYNC_NEG,
  input  logic [1:0]                    RESULT,
  input  logic [1:0]                    SHAPE,
  treasure_report_ctrl_if.master        ard,
  output logic [3:0]                    STABLE_CODE,
  output logic                          OVERRUN,
  output logic                          DROP
);

  localparam logic [3:0]       SF       = 4'(STABLE_FRAMES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RELEASE} state_t;

  logic [1:0]       vs_q, ack_q;
  logic             tick, ack_s;
  logic [3:0]       code;
  logic [3:0]       cand_q, streak_q, stable_q;
  logic             accept, accept_nz;
  logic [3:0]       pend_q;
  logic             pend_full_q, ovr_q;
  state_t           state_q, state_d;
  logic [3:0]       data_q, data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             valid_q, valid_d;
  logic             take, drop;

  // Frame-sync delay chain and two-stage synchroniser for the asynchronous ack.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vs_q  <= 2'b00;
      ack_q <= 2'b00;
    end else begin
      vs_q  <= {vs_q[0], VGA_VSYNC_NEG};
      ack_q <= {ack_q[0], ard.ARD_ACK};
    end
  end

  // One-cycle frame tick when the older chain stage is 1 and the newer one is 0.
  assign tick  = vs_q[1] & ~vs_q[0];
  assign ack_s = ack_q[1];

  // Invalid colours and missing shapes both collapse to the empty code.
  always_comb begin
    code = {RESULT, SHAPE};
    if (RESULT == 2'b00 || RESULT == 2'b11 || SHAPE == 2'b00) code = 4'b0000;
  end

  // Acceptance fires only on the tick where the streak first reaches the threshold.
  assign accept    = tick && (code == cand_q) && (streak_q == SF - 4'd1) && (cand_q != stable_q);
  assign accept_nz = accept && (cand_q != 4'b0000);

  // Stability filter: track the candidate and its streak, then latch the accepted code.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cand_q   <= 4'b0000;
      streak_q <= 4'd0;
      stable_q <= 4'b0000;
    end else if (tick) begin
      if (code == cand_q) begin
        if (streak_q != SF) streak_q <= streak_q + 4'd1;
      end else begin
        cand_q   <= code;
        streak_q <= 4'd1;
      end
      if (accept) stable_q <= cand_q;
    end
  end

  // One-deep pending buffer. The latest code wins. OVERRUN is set only if a queued
  // report is actually lost, and not when the FSM takes the old one in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q      <= 4'b0000;
      pend_full_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else if (accept_nz) begin
      pend_q      <= cand_q;
      pend_full_q <= 1'b1;
      if (pend_full_q && !take) ovr_q <= 1'b1;
    end else if (take) begin
      pend_full_q <= 1'b0;
    end
  end

  // Handshake FSM next-state logic: IDLE loads pending, SEND waits for ack or timeout,
  // and RELEASE waits for ack to drop.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    take    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_full_q) begin
          take    = 1'b1;
          data_d  = pend_q;
          tmo_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ack_s) begin
          state_d = S_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RELEASE: begin
        if (!ack_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_SEND);
  end

  // Handshake FSM state, held report data, timeout counter and registered VALID.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      data_q  <= 4'b0000;
      tmo_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
    end
  end

  assign ard.ARD_DATA  = data_q;
  assign ard.ARD_VALID = valid_q;
  assign STABLE_CODE   = stable_q;
  assign OVERRUN       = ovr_q;
  assign DROP          = drop;

endmodule

// File: tb/tb_treasure_report_ctrl.sv
// Bench for treasure_report_ctrl.
// Expected report codes are queued when stimulus makes them due. A monitor pops one
// entry on every rising ARD_VALID and compares it with ARD_DATA.
module tb_treasure_report_ctrl;
  localparam int TMO = 100;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       VSYNC;
  logic [1:0] RESULT, SHAPE;
  logic [3:0] STABLE_CODE;
  logic       OVERRUN, DROP;

  treasure_report_ctrl_if ard_if();

  treasure_report_ctrl #(
    .STABLE_FRAMES(4),
    .TIMEOUT_CYCLES(TMO),
    .TMO_W(25)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .VGA_VSYNC_NEG(VSYNC),
    .RESULT(RESULT),
    .SHAPE(SHAPE),
    .ard(ard_if),
    .STABLE_CODE(STABLE_CODE),
    .OVERRUN(OVERRUN),
    .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  int         tests = 0;
  int         fails = 0;
  int         reports = 0;
  logic [3:0] exp_q[$];
  logic       mon_prev = 1'b0;
  logic [3:0] mon_e;
  logic [3:0] flick [8];
  logic       bad;
  int         cnt;
  logic       seen;
  logic       valid_at_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one frame: data set and vsync high, then vsync low. Returns two negedges
  // after vsync falls, when the tick has been processed and STABLE_CODE is updated.
  task automatic frame(input logic [3:0] c);
    RESULT = c[3:2];
    SHAPE  = c[1:0];
    VSYNC  = 1'b1;
    repeat (3) @(negedge CLK);
    VSYNC = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_valid(input logic lvl, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      if (ard_if.ARD_VALID === lvl) break;
      @(negedge CLK);
    end
    check(name, ard_if.ARD_VALID, lvl);
  endtask

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge CLK);
      if (ard_if.ARD_VALID === 1'b1 && mon_prev !== 1'b1) begin
        reports++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_report: got data 0x%0h with nothing expected at %0t",
                   ard_if.ARD_DATA, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("report_data", ard_if.ARD_DATA, mon_e);
        end
      end
      mon_prev = ard_if.ARD_VALID;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    VSYNC = 1'b0;
    RESULT = 2'b00;
    SHAPE = 2'b00;
    ard_if.ARD_ACK = 1'b0;
    bad = 1'b0;

    // Reset with all inputs toggling.
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      VSYNC  = i[0];
      RESULT = i[1:0];
      SHAPE  = ~i[2:1];
      ard_if.ARD_ACK = i[1];
      if (ard_if.ARD_VALID !== 1'b0 || ard_if.ARD_DATA !== 4'h0 || STABLE_CODE !== 4'h0 ||
          OVERRUN !== 1'b0 || DROP !== 1'b0) bad = 1'b1;
    end
    check("reset_outputs_zero", bad, 1'b0);
    VSYNC = 1'b0; RESULT = 2'b00; SHAPE = 2'b00; ard_if.ARD_ACK = 1'b0;
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("post_reset_valid", ard_if.ARD_VALID, 1'b0);
    check("post_reset_code", STABLE_CODE, 4'h0);

    // Stable red square: three frames are not enough, and the fourth accepts it.
    for (int i = 0; i < 3; i++) begin
      frame(4'b0110);
      check("pre_accept_code", STABLE_CODE, 4'h0);
      check("pre_accept_valid", ard_if.ARD_VALID, 1'b0);
    end
    exp_q.push_back(4'b0110);
    frame(4'b0110);
    check("accept_code", STABLE_CODE, 4'h6);
    check("valid_not_yet", ard_if.ARD_VALID, 1'b0);
    @(negedge CLK);
    check("valid_2cyc", ard_if.ARD_VALID, 1'b1);
    check("data_2cyc", ard_if.ARD_DATA, 4'h6);
    ard_if.ARD_ACK = 1'b1;
    @(negedge CLK); check("valid_ack+1", ard_if.ARD_VALID, 1'b1);
    @(negedge CLK); check("valid_ack+2", ard_if.ARD_VALID, 1'b1);
    @(negedge CLK); check("valid_ack+3", ard_if.ARD_VALID, 1'b0);
    ard_if.ARD_ACK = 1'b0;
    repeat (6) @(negedge CLK);
    check("single_report_idle", ard_if.ARD_VALID, 1'b0);

    // Empty frames: accept 0000 silently.
    for (int i = 0; i < 3; i++) begin
      frame(4'b0010);
      check("nothing_hold", STABLE_CODE, 4'h6);
    end
    frame(4'b0010);
    check("nothing_accept", STABLE_CODE, 4'h0);
    repeat (3) @(negedge CLK);
    check("nothing_no_report", ard_if.ARD_VALID, 1'b0);

    // Flicker: the streak restarts at frame five, so acceptance comes on the eighth tick.
    flick = '{4'h6, 4'h6, 4'h6, 4'hB, 4'h6, 4'h6, 4'h6, 4'h6};
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(4'h6);
      frame(flick[i]);
      if (i < 7) check("flicker_hold", STABLE_CODE, 4'h0);
      else       check("flicker_accept", STABLE_CODE, 4'h6);
    end
    wait_valid(1'b1, 10, "rereport_valid");
    ard_if.ARD_ACK = 1'b1;
    wait_valid(1'b0, 10, "rereport_release");
    ard_if.ARD_ACK = 1'b0;
    repeat (5) @(negedge CLK);

    // Timeout: blue triangle with no ack.
    exp_q.push_back(4'hB);
    for (int i = 0; i < 4; i++) frame(4'b1011);
    cnt = 0; seen = 1'b0; valid_at_drop = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (ard_if.ARD_VALID === 1'b1) cnt++;
      if (DROP === 1'b1) begin
        seen = 1'b1;
        valid_at_drop = ard_if.ARD_VALID;
        break;
      end
    end
    check("drop_seen", seen, 1'b1);
    check("drop_send_cycles", cnt, TMO);
    check("valid_at_drop", valid_at_drop, 1'b1);
    @(negedge CLK);
    check("drop_one_cycle", DROP, 1'b0);
    check("valid_after_drop", ard_if.ARD_VALID, 1'b0);
    repeat (3) @(negedge CLK);

    // Overrun: ack held low while three codes are accepted in turn.
    exp_q.push_back(4'h6);
    for (int i = 0; i < 4; i++) frame(4'b0110);
    check("ovr_first_code", STABLE_CODE, 4'h6);
    for (int i = 0; i < 4; i++) frame(4'b1011);
    check("ovr_pending_no_overrun", OVERRUN, 1'b0);
    check("ovr_second_code", STABLE_CODE, 4'hB);
    for (int i = 0; i < 4; i++) frame(4'b1001);
    exp_q.push_back(4'h9);
    check("ovr_set", OVERRUN, 1'b1);
    check("ovr_third_code", STABLE_CODE, 4'h9);
    check("ovr_send_held_valid", ard_if.ARD_VALID, 1'b1);
    check("ovr_send_held_data", ard_if.ARD_DATA, 4'h6);
    ard_if.ARD_ACK = 1'b1;
    wait_valid(1'b0, 10, "ovr_release");
    ard_if.ARD_ACK = 1'b0;
    wait_valid(1'b1, 20, "ovr_next_report");
    check("ovr_next_data", ard_if.ARD_DATA, 4'h9);
    check("ovr_sticky", OVERRUN, 1'b1);

    // Asynchronous reset in mid-handshake drops VALID and loses the report.
    #2 RST_N = 1'b0;
    #1;
    check("async_reset_valid", ard_if.ARD_VALID, 1'b0);
    check("async_reset_overrun", OVERRUN, 1'b0);
    check("async_reset_code", STABLE_CODE, 4'h0);
    #1 RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    check("no_retry_after_reset", ard_if.ARD_VALID, 1'b0);

    check("report_count", reports, 5);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
